muldiv_ctrl: RTL and testbench

Sequencing controller for the shared multiply/divide resources of the EXE stage: the pipelined 33x33 signed multiplier and the AXI-stream 33-bit signed divider core. Accepts one mul/mulu/div/divu request at a time, drives operand sign/zero extension and the divider AXIS handshakes, counts multiplier latency, and holds the {HI,LO} result until the downstream stage accepts it. Handles exception cancel without corrupting the divider core.

---
 rtl/muldiv_ctrl_if.sv | 39 +++
 rtl/muldiv_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// Request/result, multiplier and divider AXIS signals of the mul/div sequencer.
// slave = controller side, master = pipeline/arithmetic-core side.
interface muldiv_ctrl_if;
    logic        op_valid;
    logic [3:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        op_ready;
    logic        cancel;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic [32:0] mul_a;
    logic [32:0] mul_b;
    logic [65:0] mul_p;
    logic        dvd_tvalid;
    logic        dvd_tready;
    logic [32:0] dvd_tdata;
    logic        dvs_tvalid;
    logic        dvs_tready;
    logic [32:0] dvs_tdata;
    logic        dout_tvalid;
    logic [79:0] dout_tdata;

    modport slave (
        input  op_valid, op, src1, src2, cancel, res_ready, mul_p,
               dvd_tready, dvs_tready, dout_tvalid, dout_tdata,
        output op_ready, res_valid, res_hi, res_lo, mul_a, mul_b,
               dvd_tvalid, dvd_tdata, dvs_tvalid, dvs_tdata
    );

    modport master (
        output op_valid, op, src1, src2, cancel, res_ready, mul_p,
               dvd_tready, dvs_tready, dout_tvalid, dout_tdata,
        input  op_ready, res_valid, res_hi, res_lo, mul_a, mul_b,
               dvd_tvalid, dvd_tdata, dvs_tvalid, dvs_tdata
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared pipelined multiplier and AXIS divider core.
// Optional macro DIV_ZERO_FAST_EN: divide by zero bypasses the divider core.
module muldiv_ctrl #(
    parameter int MUL_LAT = 5
) (
    input logic          clk,
    input logic          resetn,
    muldiv_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, MUL_WAIT, DIV_SEND, DIV_WAIT, DIV_DRAIN, DONE
    } state_t;

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [32:0]      opa_q, opa_d, opb_q, opb_d;
    logic             dvd_tvalid_q, dvd_tvalid_d, dvs_tvalid_q, dvs_tvalid_d;
    logic             dvd_sent_q, dvd_sent_d, dvs_sent_q, dvs_sent_d;
    logic             kill_q, kill_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_hi_q, res_hi_d, res_lo_q, res_lo_d;

    logic        is_mul, is_mulu, is_div, is_signed, accept, div_fast;
    logic        dvd_done, dvs_done;
    logic [32:0] ext_a, ext_b;
    logic        unused_bits;

    // One-hot op with priority mul > mulu > div > divu
    assign is_mul    = bus.op[0];
    assign is_mulu   = bus.op[1] & ~bus.op[0];
    assign is_div    = bus.op[2] & ~bus.op[1] & ~bus.op[0];
    assign is_signed = is_mul | is_div;
    assign accept    = bus.op_valid & (state_q == IDLE) & ~bus.cancel & (|bus.op);
    assign ext_a     = {is_signed & bus.src1[31], bus.src1};
    assign ext_b     = {is_signed & bus.src2[31], bus.src2};

`ifdef DIV_ZERO_FAST_EN
    assign div_fast = (bus.src2 == 32'd0);
`else
    assign div_fast = 1'b0;
`endif

    // A channel counts as sent if it handshakes on this very edge too
    assign dvd_done = dvd_sent_q | (dvd_tvalid_q & bus.dvd_tready);
    assign dvs_done = dvs_sent_q | (dvs_tvalid_q & bus.dvs_tready);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        dvd_tvalid_d = dvd_tvalid_q;
        dvs_tvalid_d = dvs_tvalid_q;
        dvd_sent_d   = dvd_sent_q;
        dvs_sent_d   = dvs_sent_q;
        kill_d       = kill_q;
        res_valid_d  = res_valid_q;
        res_hi_d     = res_hi_q;
        res_lo_d     = res_lo_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    opa_d = ext_a;
                    opb_d = ext_b;
                    if (is_mul | is_mulu) begin
                        state_d = MUL_WAIT;
                        cnt_d   = CNT_W'(1);
                    end else if (div_fast) begin
                        state_d     = DONE;
                        res_lo_d    = 32'hFFFF_FFFF;
                        res_hi_d    = bus.src1;
                        res_valid_d = 1'b1;
                    end else begin
                        state_d      = DIV_SEND;
                        dvd_tvalid_d = 1'b1;
                        dvs_tvalid_d = 1'b1;
                        dvd_sent_d   = 1'b0;
                        dvs_sent_d   = 1'b0;
                        kill_d       = 1'b0;
                    end
                end
            end
            MUL_WAIT: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(MUL_LAT)) begin
                    state_d     = DONE;
                    cnt_d       = '0;
                    res_hi_d    = bus.mul_p[63:32];
                    res_lo_d    = bus.mul_p[31:0];
                    res_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DIV_SEND: begin
                if (dvd_tvalid_q & bus.dvd_tready) begin
                    dvd_tvalid_d = 1'b0;
                    dvd_sent_d   = 1'b1;
                end
                if (dvs_tvalid_q & bus.dvs_tready) begin
                    dvs_tvalid_d = 1'b0;
                    dvs_sent_d   = 1'b1;
                end
                if (bus.cancel & ~dvd_done & ~dvs_done) begin
                    state_d      = IDLE;
                    dvd_tvalid_d = 1'b0;
                    dvs_tvalid_d = 1'b0;
                    kill_d       = 1'b0;
                end else begin
                    // Half-sent op must still complete so the core is not left waiting
                    kill_d = kill_q | bus.cancel;
                    if (dvd_done & dvs_done) begin
                        state_d    = (kill_q | bus.cancel) ? DIV_DRAIN : DIV_WAIT;
                        kill_d     = 1'b0;
                        dvd_sent_d = 1'b0;
                        dvs_sent_d = 1'b0;
                    end
                end
            end
            DIV_WAIT: begin
                if (bus.cancel) begin
                    state_d = bus.dout_tvalid ? IDLE : DIV_DRAIN;
                end else if (bus.dout_tvalid) begin
                    state_d     = DONE;
                    res_lo_d    = bus.dout_tdata[71:40];
                    res_hi_d    = bus.dout_tdata[31:0];
                    res_valid_d = 1'b1;
                end
            end
            DIV_DRAIN: begin
                if (bus.dout_tvalid) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (bus.cancel | bus.res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            dvd_tvalid_q <= 1'b0;
            dvs_tvalid_q <= 1'b0;
            dvd_sent_q   <= 1'b0;
            dvs_sent_q   <= 1'b0;
            kill_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_hi_q     <= '0;
            res_lo_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            dvd_tvalid_q <= dvd_tvalid_d;
            dvs_tvalid_q <= dvs_tvalid_d;
            dvd_sent_q   <= dvd_sent_d;
            dvs_sent_q   <= dvs_sent_d;
            kill_q       <= kill_d;
            res_valid_q  <= res_valid_d;
            res_hi_q     <= res_hi_d;
            res_lo_q     <= res_lo_d;
        end
    end

    assign bus.op_ready   = (state_q == IDLE);
    assign bus.res_valid  = res_valid_q;
    assign bus.res_hi     = res_hi_q;
    assign bus.res_lo     = res_lo_q;
    assign bus.mul_a      = opa_q;
    assign bus.mul_b      = opb_q;
    assign bus.dvd_tvalid = dvd_tvalid_q;
    assign bus.dvd_tdata  = opa_q;
    assign bus.dvs_tvalid = dvs_tvalid_q;
    assign bus.dvs_tdata  = opb_q;

    // Product/divider bits that never reach the 32-bit result registers
    assign unused_bits = ^{bus.mul_p[65:64], bus.dout_tdata[79:72], bus.dout_tdata[39:32]};
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with behavioural multiplier and divider core.
module tb_muldiv_ctrl;
    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb_q[$];

    muldiv_ctrl_if bus();
    muldiv_ctrl #(.MUL_LAT(5)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational stand-in for the multiplier (operands are held for the whole op)
    logic signed [65:0] pa, pb;
    assign pa = {{33{bus.mul_a[32]}}, bus.mul_a};
    assign pb = {{33{bus.mul_b[32]}}, bus.mul_b};
    assign bus.mul_p = pa * pb;

    // Divider core: takes both operands, answers 3 cycles later with a 1-cycle pulse
    logic [32:0] cm_a, cm_b;
    logic signed [32:0] sq, sr;
    bit got_a, got_b;
    int busy;
    initial begin
        bus.dout_tvalid = 1'b0;
        bus.dout_tdata  = '0;
        got_a = 0; got_b = 0; busy = 0;
        forever begin
            @(negedge clk); #1;
            bus.dout_tvalid = 1'b0;
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    if (cm_b == 33'd0) begin
                        sq = '1;
                        sr = $signed(cm_a);
                    end else begin
                        sq = $signed(cm_a) / $signed(cm_b);
                        sr = $signed(cm_a) % $signed(cm_b);
                    end
                    bus.dout_tdata  = {8'h00, sq[31:0], 8'h00, sr[31:0]};
                    bus.dout_tvalid = 1'b1;
                end
            end
            if (resetn && bus.dvd_tvalid && bus.dvd_tready) begin cm_a = bus.dvd_tdata; got_a = 1; end
            if (resetn && bus.dvs_tvalid && bus.dvs_tready) begin cm_b = bus.dvs_tdata; got_b = 1; end
            if (got_a && got_b) begin got_a = 0; got_b = 0; busy = 3; end
        end
    end

    // Monitor: compares every cycle a result is presented
    bit prev_v = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (!resetn) begin
                prev_v = 0;
            end else begin
                if (bus.res_valid) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_result hi=%h lo=%h (no result expected)", bus.res_hi, bus.res_lo);
                    end else begin
                        e = sb_q[0];
                        if (bus.res_hi !== e.hi || bus.res_lo !== e.lo) begin
                            errors++;
                            $display("FAIL result hi=%h lo=%h expected hi=%h lo=%h", bus.res_hi, bus.res_lo, e.hi, e.lo);
                        end else begin
                            $display("result hi=%h lo=%h ok at cycle %0d", bus.res_hi, bus.res_lo, cyc);
                        end
                        if (!prev_v && e.lat >= 0) begin
                            checks++;
                            if (cyc - e.acc != e.lat) begin
                                errors++;
                                $display("FAIL latency got=%0d expected=%0d", cyc - e.acc, e.lat);
                            end
                        end
                        if (bus.res_ready) void'(sb_q.pop_front());
                    end
                end
                prev_v = bus.res_valid && !bus.res_ready;
            end
        end
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.op_ready && n < 100) begin @(negedge clk); n++; end
        if (!bus.op_ready) begin
            checks++; errors++;
            $display("FAIL op_ready_timeout got=0 expected=1");
        end
    endtask

    task automatic issue(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] hi, input logic [31:0] lo, input int lat);
        exp_t e;
        wait_ready();
        bus.op_valid = 1'b1; bus.op = opc; bus.src1 = a; bus.src2 = b;
        $display("issue op=%b src1=%h src2=%h at cycle %0d", opc, a, b, cyc);
        if (push) begin
            e.hi = hi; e.lo = lo; e.lat = lat; e.acc = cyc;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.op_valid = 1'b0; bus.op = 4'd0;
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        bus.op_valid = 1'b0; bus.op = 4'd0; bus.src1 = '0; bus.src2 = '0;
        bus.cancel = 1'b0; bus.res_ready = 1'b1;
        bus.dvd_tready = 1'b1; bus.dvs_tready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_op_ready", bus.op_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_hi", bus.res_hi, 0);
        chk("rst_res_lo", bus.res_lo, 0);
        chk("rst_dvd_tvalid", bus.dvd_tvalid, 0);
        chk("rst_dvs_tvalid", bus.dvs_tvalid, 0);
        chk("rst_mul_a", bus.mul_a, 0);
        resetn = 1'b1;
        @(negedge clk);

        // signed / unsigned multiply
        issue(4'b0001, 32'hFFFF_FFFF, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6);
        chk("mul_a_signed", bus.mul_a, 33'h1_FFFF_FFFF);
        chk("mul_b_signed", bus.mul_b, 33'h0_0000_0002);
        issue(4'b0010, 32'hFFFF_FFFF, 32'd2, 1, 32'h0000_0001, 32'hFFFF_FFFE, 6);
        chk("mul_a_unsigned", bus.mul_a, 33'h0_FFFF_FFFF);

        // signed divide with divisor channel stalled
        wait_ready();
        bus.dvs_tready = 1'b0;
        issue(4'b0100, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
        chk("div_dvd_tvalid_c1", bus.dvd_tvalid, 1);
        chk("div_dvs_tvalid_c1", bus.dvs_tvalid, 1);
        chk("div_dvd_tdata", bus.dvd_tdata, 33'h1_FFFF_FFF9);
        chk("div_dvs_tdata", bus.dvs_tdata, 33'h0_0000_0002);
        @(negedge clk);
        chk("div_dvd_tvalid_c2", bus.dvd_tvalid, 0);
        chk("div_dvs_tvalid_c2", bus.dvs_tvalid, 1);
        @(negedge clk);
        chk("div_dvd_tvalid_c3", bus.dvd_tvalid, 0);
        chk("div_dvs_tvalid_c3", bus.dvs_tvalid, 1);
        bus.dvs_tready = 1'b1;
        @(negedge clk);
        chk("div_dvs_tvalid_c4", bus.dvs_tvalid, 0);

        // unsigned divide with result backpressure
        wait_ready();
        bus.res_ready = 1'b0;
        issue(4'b1000, 32'd100, 32'd7, 1, 32'd2, 32'd14, -1);
        n = 0;
        while (!bus.res_valid && n < 50) begin @(negedge clk); n++; end
        chk("divu_res_valid_seen", bus.res_valid, 1);
        for (int i = 0; i < 4; i++) begin
            chk("divu_hold_op_ready", bus.op_ready, 0);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        chk("divu_op_ready_at_accept", bus.op_ready, 0);
        @(negedge clk);
        chk("divu_op_ready_after", bus.op_ready, 1);
        chk("divu_res_valid_after", bus.res_valid, 0);

        // cancel in DIV_WAIT drains the core result
        issue(4'b0100, 32'd9, 32'd3, 0, 32'd0, 32'd0, -1);
        @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        chk("drain_op_ready_c3", bus.op_ready, 0);
        @(negedge clk);
        chk("drain_op_ready_c4", bus.op_ready, 0);
        @(negedge clk);
        chk("drain_op_ready_c5", bus.op_ready, 1);
        issue(4'b0001, 32'd3, 32'd5, 1, 32'd0, 32'd15, 6);

        // reset in the middle of a multiply
        issue(4'b0001, 32'd4, 32'd4, 0, 32'd0, 32'd0, -1);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_op_ready", bus.op_ready, 1);
        chk("midrst_res_valid", bus.res_valid, 0);
        resetn = 1'b1;
        @(negedge clk);
        issue(4'b0001, 32'd7, 32'd6, 1, 32'd0, 32'd42, 6);

        // cancel in MUL_WAIT, op=0 ignored, cancel in IDLE blocks accept
        issue(4'b0001, 32'd2, 32'd2, 0, 32'd0, 32'd0, -1);
        @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        chk("mulcancel_op_ready", bus.op_ready, 1);
        bus.op_valid = 1'b1; bus.op = 4'b0000;
        @(negedge clk);
        chk("op_zero_ignored", bus.op_ready, 1);
        bus.op = 4'b0001; bus.cancel = 1'b1;
        @(negedge clk);
        chk("idle_cancel_blocks", bus.op_ready, 1);
        bus.op_valid = 1'b0; bus.op = 4'd0; bus.cancel = 1'b0;

        // multi-hot priority
        issue(4'b1101, 32'hFFFF_FFFF, 32'd3, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 6);
        issue(4'b0110, 32'hFFFF_FFFF, 32'd3, 1, 32'h0000_0002, 32'hFFFF_FFFD, 6);

        // cancel in DIV_SEND before either channel handshakes
        wait_ready();
        bus.dvd_tready = 1'b0; bus.dvs_tready = 1'b0;
        issue(4'b0100, 32'd8, 32'd2, 0, 32'd0, 32'd0, -1);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        chk("send_cancel_op_ready", bus.op_ready, 1);
        chk("send_cancel_dvd_tvalid", bus.dvd_tvalid, 0);
        chk("send_cancel_dvs_tvalid", bus.dvs_tvalid, 0);

        // cancel in DIV_SEND after only the dividend went out
        bus.dvd_tready = 1'b1;
        issue(4'b0100, 32'd8, 32'd2, 0, 32'd0, 32'd0, -1);
        @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        chk("half_cancel_dvs_tvalid", bus.dvs_tvalid, 1);
        chk("half_cancel_dvd_tvalid", bus.dvd_tvalid, 0);
        chk("half_cancel_op_ready", bus.op_ready, 0);
        bus.dvs_tready = 1'b1;

        // divide by zero
`ifdef DIV_ZERO_FAST_EN
        issue(4'b0100, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1);
        chk("divzero_dvd_tvalid", bus.dvd_tvalid, 0);
`else
        issue(4'b0100, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, -1);
`endif

        n = 0;
        while (sb_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", sb_q.size());
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
